// File: rtl/io_pkg.sv
// io_pkg: shared pin-sampler constants, FSM encoding and event record sizing
package io_pkg;

    localparam int IO_NUM_OF_DEF = 10;
    localparam int TS_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // An event is {timestamp, masked pins}; the timestamp occupies the upper bits.
    function automatic int evt_width(input int ts_w, input int io_w);
        return ts_w + io_w;
    endfunction

    localparam int EVT_WIDTH_DEF = evt_width(TS_WIDTH_DEF, IO_NUM_OF_DEF);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: fall-through FIFO with extra-MSB pointers; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign level   = wr_q - rd_q;
    assign rd_data = mem_q[rd_q[AW-1:0]];

    // Pointer advance; reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + {{AW{1'b0}}, do_wr};
            rd_q <= rd_q + {{AW{1'b0}}, do_rd};
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/io_pin_sampler.sv
// io_pin_sampler: synchronises pad inputs and logs timestamped change events into a host-drained FIFO
module io_pin_sampler
    import io_pkg::*;
#(
    parameter int IO_NUM_OF  = IO_NUM_OF_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = TS_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IO_NUM_OF-1:0]          in_io_inval,
    input  logic [IO_NUM_OF-1:0]          in_io_direction,
    input  logic                          in_enable,
    output logic                          out_evt_valid,
    input  logic                          in_evt_ready,
    output logic [IO_NUM_OF-1:0]          out_evt_pins,
    output logic [TS_WIDTH-1:0]           out_evt_ts,
    output logic                          out_overflow,
    input  logic                          in_overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   out_fifo_level
);

    localparam int EW = evt_width(TS_WIDTH, IO_NUM_OF);

    logic [IO_NUM_OF-1:0] sync1_q, sync2_q, last_q, last_d, masked;
    logic [TS_WIDTH-1:0]  ts_q;
    state_e               state_q, state_d;
    logic                 ovf_q, ovf_d;
    logic                 push, pop, full, empty;
    logic [EW-1:0]        rd_data;

    assign masked = sync2_q & ~in_io_direction;
    assign pop    = !empty && in_evt_ready;

    // Next state, commit of the last-seen pin vector and push request.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        push    = 1'b0;
        if (!in_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    push    = 1'b1;
                    last_d  = masked;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    push   = masked != last_q;
                    last_d = masked;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A dropped push sets the sticky flag and takes priority over clear.
    always_comb begin
        ovf_d = (push && full && !pop) ? 1'b1 : (in_overflow_clr ? 1'b0 : ovf_q);
    end

    // Synchroniser, timestamp counter, FSM and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            ts_q    <= '0;
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= in_io_inval;
            sync2_q <= sync1_q;
            last_q  <= last_d;
            ts_q    <= ts_q + 1'b1;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({ts_q, masked}),
        .full    (full),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (empty),
        .level   (out_fifo_level)
    );

    assign out_evt_valid = !empty;
    assign out_evt_pins  = empty ? '0 : rd_data[IO_NUM_OF-1:0];
    assign out_evt_ts    = empty ? '0 : rd_data[EW-1:IO_NUM_OF];
    assign out_overflow  = ovf_q;

endmodule

// File: tb/tb_io_pin_sampler.sv
// tb_io_pin_sampler: directed vector table plus hand-written overflow and reset sequences
module tb_io_pin_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  inval = '0, dir = '0;
    logic        en = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic        valid, ovf;
    logic [9:0]  pins;
    logic [15:0] ts;
    logic [4:0]  level;

    int checks = 0;
    int errors = 0;
    int ec = 0;
    int e0, t5;

    typedef struct {
        logic [9:0]  dir;
        logic [9:0]  pads;
        logic        en;
        logic        rdy;
        logic        v;
        logic [9:0]  pins;
        logic [15:0] ts;
        logic [4:0]  lvl;
    } vec_t;

    vec_t tv [21];

    always #5 clk = ~clk;

    io_pin_sampler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_io_inval     (inval),
        .in_io_direction (dir),
        .in_enable       (en),
        .out_evt_valid   (valid),
        .in_evt_ready    (rdy),
        .out_evt_pins    (pins),
        .out_evt_ts      (ts),
        .out_overflow    (ovf),
        .in_overflow_clr (clr),
        .out_fifo_level  (level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [9:0] p, input logic [15:0] t);
        chk({name, ".valid"}, 32'(valid), 32'd1);
        chk({name, ".pins"}, 32'(pins), 32'(p));
        chk({name, ".ts"}, 32'(ts), 32'(t));
    endtask

    initial begin
        //        dir     pads    en    rdy   v     pins    ts      lvl
        tv[0]  = '{10'h000, 10'h2AA, 1'b0, 1'b0, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[1]  = '{10'h000, 10'h2AA, 1'b0, 1'b0, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[2]  = '{10'h000, 10'h2AA, 1'b1, 1'b0, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[3]  = '{10'h000, 10'h2AA, 1'b1, 1'b0, 1'b1, 10'h2AA, 16'd3,  5'd1};
        tv[4]  = '{10'h000, 10'h2AA, 1'b1, 1'b0, 1'b1, 10'h2AA, 16'd3,  5'd1};
        tv[5]  = '{10'h000, 10'h2AA, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[6]  = '{10'h000, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[7]  = '{10'h000, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[8]  = '{10'h000, 10'h155, 1'b1, 1'b1, 1'b1, 10'h155, 16'd8,  5'd1};
        tv[9]  = '{10'h000, 10'h155, 1'b1, 1'b0, 1'b1, 10'h155, 16'd8,  5'd1};
        tv[10] = '{10'h000, 10'h155, 1'b1, 1'b0, 1'b1, 10'h155, 16'd8,  5'd1};
        tv[11] = '{10'h000, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[12] = '{10'h000, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[13] = '{10'h3FF, 10'h155, 1'b1, 1'b1, 1'b1, 10'h000, 16'd13, 5'd1};
        tv[14] = '{10'h3FF, 10'h2AA, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[15] = '{10'h3FF, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[16] = '{10'h3FF, 10'h3A5, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[17] = '{10'h3FF, 10'h3A5, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};
        tv[18] = '{10'h000, 10'h3A5, 1'b1, 1'b0, 1'b1, 10'h3A5, 16'd18, 5'd1};
        tv[19] = '{10'h000, 10'h3A5, 1'b1, 1'b0, 1'b1, 10'h3A5, 16'd18, 5'd1};
        tv[20] = '{10'h000, 10'h3A5, 1'b1, 1'b1, 1'b0, 10'h000, 16'd0,  5'd0};

        inval = 10'h2AA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.pins", 32'(pins), 32'd0);
        chk("rst.ts", 32'(ts), 32'd0);
        rst_n = 1'b1;
        ec = 0;

        for (int i = 0; i < 21; i++) begin
            dir   = tv[i].dir;
            inval = tv[i].pads;
            en    = tv[i].en;
            rdy   = tv[i].rdy;
            tick();
            chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(tv[i].v));
            chk($sformatf("vec%0d.pins", i), 32'(pins), 32'(tv[i].pins));
            chk($sformatf("vec%0d.ts", i), 32'(ts), 32'(tv[i].ts));
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(tv[i].lvl));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'd0);
        end

        rdy = 1'b0;
        e0 = ec;
        for (int k = 0; k < 20; k++) begin
            inval = 10'(k + 1);
            tick();
        end
        tick();
        tick();
        chk("fill.level", 32'(level), 32'd16);
        chk("fill.ovf", 32'(ovf), 32'd1);
        chk_head("fill.head", 10'd1, 16'(e0 + 2));

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr.ovf", 32'(ovf), 32'd0);
        chk("clr.level", 32'(level), 32'd16);

        inval = 10'h3FF;
        tick();
        tick();
        rdy = 1'b1;
        t5 = ec;
        tick();
        rdy = 1'b0;
        chk("pushpop.level", 32'(level), 32'd16);
        chk("pushpop.ovf", 32'(ovf), 32'd0);

        rdy = 1'b1;
        for (int k = 1; k < 16; k++) begin
            chk_head($sformatf("drain%0d", k), 10'(k + 1), 16'(e0 + k + 2));
            tick();
        end
        chk_head("drain.last", 10'h3FF, 16'(t5));
        tick();
        chk("drain.valid", 32'(valid), 32'd0);
        chk("drain.level", 32'(level), 32'd0);

        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            inval = 10'h010 + 10'(k);
            tick();
        end
        tick();
        tick();
        chk("burst.level", 32'(level), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(valid), 32'd0);
        chk("arst.level", 32'(level), 32'd0);
        chk("arst.pins", 32'(pins), 32'd0);
        en = 1'b0;
        #1;
        rst_n = 1'b1;
        ec = 0;
        tick();
        tick();
        en = 1'b1;
        tick();
        tick();
        chk_head("rearm", 10'h014, 16'd3);
        chk("rearm.level", 32'(level), 32'd1);
        tick();
        chk("rearm.stable", 32'(level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
